// File: rtl/bcd_seq_ctrl.sv
// Multi-byte packed-BCD add/subtract sequencer: reads A and B byte by byte from memory,
// writes the decimal-adjusted result back over A, least significant byte first.
//   state | meaning
//   IDLE  | waiting for start, flags hold last result
//   RD_A  | reading byte i of operand A
//   RD_B  | reading byte i of operand B
//   WR    | writing result byte i to A
//   DONE  | one-cycle completion pulse
module bcd_seq_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              add_sub,
  input  logic              carry_in,
  input  logic [2:0]        len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [3:0]        flags
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a_base_q, b_base_q;
  logic [2:0]        len_q, idx_q;
  logic              sub_q, carry_q, zero_q;
  logic [7:0]        byte_a_q, byte_b_q;
  logic [1:0]        flags_q;

  logic [4:0]        nib_lo, nib_hi;
  logic [7:0]        result;
  logic              byte_cout;
  logic [ADDR_W-1:0] idx_ext, addr_a, addr_b;

  // Returns {carry, digit}; t is taken modulo 32 so a borrow shows up as t > 9.
  function automatic logic [4:0] bcd_nib(input logic sub, input logic [3:0] a,
                                         input logic [3:0] b, input logic c);
    logic [4:0] t;
    if (sub) t = {1'b0, a} - {1'b0, b} - {4'b0, c};
    else     t = {1'b0, a} + {1'b0, b} + {4'b0, c};
    if (t > 5'd9) return {1'b1, (sub ? t[3:0] - 4'd6 : t[3:0] + 4'd6)};
    else          return {1'b0, t[3:0]};
  endfunction

  always_comb begin
    nib_lo    = bcd_nib(sub_q, byte_a_q[3:0], byte_b_q[3:0], carry_q);
    nib_hi    = bcd_nib(sub_q, byte_a_q[7:4], byte_b_q[7:4], nib_lo[4]);
    result    = {nib_hi[3:0], nib_lo[3:0]};
    byte_cout = nib_hi[4];
    idx_ext   = {{(ADDR_W-3){1'b0}}, idx_q};
    addr_a    = a_base_q + idx_ext;
    addr_b    = b_base_q + idx_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = RD_A;
      end
      RD_A: begin
        mem_rd   = 1'b1;
        mem_addr = addr_a;
        if (mem_ready) state_d = RD_B;
      end
      RD_B: begin
        mem_rd   = 1'b1;
        mem_addr = addr_b;
        if (mem_ready) state_d = WR;
      end
      WR: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_a;
        mem_wdata = result;
        if (mem_ready) state_d = (idx_q == len_q) ? DONE : RD_A;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_base_q <= '0;
      b_base_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      byte_a_q <= '0;
      byte_b_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_base_q <= a_base;
          b_base_q <= b_base;
          len_q    <= len;
          sub_q    <= add_sub;
          idx_q    <= '0;
          carry_q  <= carry_in;
          zero_q   <= 1'b1;
          flags_q  <= '0;
        end
        RD_A: if (mem_ready) byte_a_q <= mem_rdata;
        RD_B: if (mem_ready) byte_b_q <= mem_rdata;
        WR: if (mem_ready) begin
          carry_q <= byte_cout;
          zero_q  <= zero_q & (result == 8'h00);
          if (idx_q == len_q) flags_q <= {byte_cout, zero_q & (result == 8'h00)};
          else                idx_q   <= idx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign flags = {2'b00, flags_q};

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Scoreboard bench for bcd_seq_ctrl: expected memory accesses and completions are queued
// by the driver and retired by a monitor watching the memory port and done.
module tb_bcd_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        add_sub = 1'b0;
  logic        carry_in = 1'b0;
  logic [2:0]  len = '0;
  logic [15:0] a_base = '0, b_base = '0;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr, mem_ready;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy, done;
  logic [3:0]  flags;

  bcd_seq_ctrl #(.ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .add_sub(add_sub), .carry_in(carry_in),
    .len(len), .a_base(a_base), .b_base(b_base), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .flags(flags)
  );

  always #5 clk = ~clk;

  // memory model with a programmable number of wait cycles per access
  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  int          wait_cfg = 0;
  int          wait_cnt = 0;

  assign mem_ready = (mem_rd || mem_wr) && (wait_cnt == wait_cfg);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_wr && mem_ready) mem[mem_addr] <= mem_wdata;
    if ((mem_rd || mem_wr) && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                                  wait_cnt <= 0;
  end

  typedef struct {logic wr; logic [15:0] addr; logic [7:0] data;} acc_t;
  typedef struct {logic [3:0] flags; longint t_acc; int cycles;} done_t;
  acc_t  acc_q[$];
  done_t done_q[$];
  int    checks = 0;
  int    errors = 0;
  int    wr_cnt = 0;

  // monitor
  initial begin
    logic        prev_pend;
    logic [25:0] prev_sig;
    acc_t        ea;
    done_t       ed;
    int          cyc;
    prev_pend = 1'b0;
    prev_sig  = '0;
    forever begin
      @(negedge clk);
      if (mem_rd || mem_wr) begin
        checks++;
        if (mem_rd && mem_wr) begin
          errors++;
          $display("FAIL strobe_excl: rd=%0b wr=%0b, required not both", mem_rd, mem_wr);
        end
      end
      if (reset_n && prev_pend) begin
        checks++;
        if ({mem_addr, mem_rd, mem_wr, mem_wdata} !== prev_sig) begin
          errors++;
          $display("FAIL hold_stable: got %h, required %h", {mem_addr, mem_rd, mem_wr, mem_wdata}, prev_sig);
        end
      end
      if ((mem_rd || mem_wr) && mem_ready) begin
        if (mem_wr) wr_cnt++;
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL access_unexpected: wr=%0b addr=%h, required none", mem_wr, mem_addr);
        end else begin
          ea = acc_q.pop_front();
          if (ea.wr !== mem_wr || ea.addr !== mem_addr || (ea.wr && ea.data !== mem_wdata)) begin
            errors++;
            $display("FAIL access: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                     mem_wr, mem_addr, mem_wdata, ea.wr, ea.addr, ea.data);
          end
        end
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done=1, required 0");
        end else begin
          ed  = done_q.pop_front();
          cyc = int'(($time - 5 - ed.t_acc) / 10);
          if (flags !== ed.flags || cyc != ed.cycles) begin
            errors++;
            $display("FAIL done: got flags=%b cycles=%0d, required flags=%b cycles=%0d",
                     flags, cyc, ed.flags, ed.cycles);
          end
        end
      end
      prev_pend = reset_n && (mem_rd || mem_wr) && !mem_ready;
      prev_sig  = {mem_addr, mem_rd, mem_wr, mem_wdata};
    end
  end

  task automatic load_bytes(input logic [15:0] base, input int n, input logic [63:0] v);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = base + 16'(i);
      pl_data = v[8*i +: 8];
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic push_acc(input logic wr, input logic [15:0] addr, input logic [7:0] data);
    acc_t a;
    a.wr = wr; a.addr = addr; a.data = data;
    acc_q.push_back(a);
  endtask

  task automatic issue_start(input logic sub, input logic cin, input int n,
                             input logic [15:0] ab, input logic [15:0] bb, output longint t);
    @(negedge clk);
    add_sub = sub; carry_in = cin; len = n[2:0]; a_base = ab; b_base = bb; start = 1'b1;
    @(posedge clk);
    t = $time;
    #1;
    // scramble inputs after acceptance: the operation must use its latched copies
    start = 1'b0; a_base = 16'hDEAD; b_base = 16'hBEEF;
    len = ~len; add_sub = ~add_sub; carry_in = ~carry_in;
  endtask

  task automatic run_op(input logic sub, input logic cin, input int n,
                        input logic [15:0] ab, input logic [15:0] bb,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] res, input logic [3:0] fl,
                        input int w, input bit poke);
    longint t;
    done_t  d;
    bit     got;
    logic [15:0] ad;
    load_bytes(ab, n, av);
    load_bytes(bb, n, bv);
    wait_cfg = w;
    for (int i = 0; i <= n; i++) begin
      push_acc(1'b0, ab + 16'(i), 8'h00);
      push_acc(1'b0, bb + 16'(i), 8'h00);
      push_acc(1'b1, ab + 16'(i), res[8*i +: 8]);
    end
    issue_start(sub, cin, n, ab, bb, t);
    d.flags = fl; d.t_acc = t; d.cycles = 3 * (n + 1) * (w + 1);
    done_q.push_back(d);
    if (poke) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: done not seen, required within 400 cycles");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || flags !== fl) begin
      errors++;
      $display("FAIL idle_hold: got busy=%0b flags=%b, required busy=0 flags=%b", busy, flags, fl);
    end
    for (int i = 0; i <= n; i++) begin
      ad = ab + 16'(i);
      checks++;
      if (mem[ad] !== res[8*i +: 8]) begin
        errors++;
        $display("FAIL mem_result: addr=%h got %h, required %h", ad, mem[ad], res[8*i +: 8]);
      end
    end
  endtask

  initial begin
    longint t;
    bit     found;
    int     wr_save;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, mem_rd, mem_wr, mem_addr, mem_wdata, flags} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b rd=%0b wr=%0b addr=%h wdata=%h flags=%b, required all 0",
               busy, done, mem_rd, mem_wr, mem_addr, mem_wdata, flags);
    end
    reset_n = 1'b1;

    run_op(1'b0, 1'b0, 0, 16'h0010, 16'h0020, 64'h45, 64'h38, 64'h83, 4'b0000, 0, 1'b0);
    run_op(1'b0, 1'b0, 1, 16'h0100, 16'h0200, 64'h0099, 64'h0001, 64'h0100, 4'b0000, 0, 1'b1);
    run_op(1'b1, 1'b0, 0, 16'h0030, 16'h0040, 64'h00, 64'h01, 64'h99, 4'b0010, 0, 1'b0);
    run_op(1'b0, 1'b0, 0, 16'h0050, 16'h0060, 64'h50, 64'h50, 64'h00, 4'b0011, 0, 1'b0);
    run_op(1'b0, 1'b1, 2, 16'h0300, 16'h0400, 64'h123456, 64'h789012, 64'h912469, 4'b0000, 0, 1'b0);
    run_op(1'b0, 1'b1, 2, 16'h0300, 16'h0400, 64'h123456, 64'h789012, 64'h912469, 4'b0000, 3, 1'b0);
    run_op(1'b1, 1'b1, 1, 16'hFFFF, 16'h7FFF, 64'h1000, 64'h0000, 64'h0999, 4'b0000, 0, 1'b0);
    run_op(1'b0, 1'b0, 7, 16'h0500, 16'h0600, 64'h9999999999999999, 64'h1, 64'h0, 4'b0011, 1, 1'b0);

    // abort during the second RD_B of a 4-byte add
    load_bytes(16'h1000, 3, 64'h44332211);
    load_bytes(16'h2000, 3, 64'h88776655);
    wait_cfg = 2;
    push_acc(1'b0, 16'h1000, 8'h00);
    push_acc(1'b0, 16'h2000, 8'h00);
    push_acc(1'b1, 16'h1000, 8'h66);
    push_acc(1'b0, 16'h1001, 8'h00);
    issue_start(1'b0, 1'b0, 3, 16'h1000, 16'h2000, t);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 16'h2001) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_reach: second RD_B not seen, required within 200 cycles");
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_rd, mem_wr, mem_addr, mem_wdata, flags} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%0b done=%0b rd=%0b wr=%0b addr=%h wdata=%h flags=%b, required all 0",
               busy, done, mem_rd, mem_wr, mem_addr, mem_wdata, flags);
    end
    wr_save = wr_cnt;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (wr_cnt != wr_save || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: got writes=%0d busy=%0b, required writes=%0d busy=0", wr_cnt, busy, wr_save);
    end
    checks++;
    if (acc_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got acc=%0d done=%0d pending, required 0 and 0", acc_q.size(), done_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the memory address width.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request for a new operation.
REQ-005 SHALL have port add_sub, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-006 SHALL have port carry_in, input, 1 bit: initial carry or borrow for byte 0.
REQ-007 SHALL have port len, input, 3 bits: operand length in bytes, minus 1 (1..8 bytes).
REQ-008 SHALL have port a_base, input, ADDR_W bits: address of byte 0 of operand A, which is also the destination.
REQ-009 SHALL have port b_base, input, ADDR_W bits: address of byte 0 of operand B.
REQ-010 SHALL have port mem_addr, output, ADDR_W bits: memory address.
REQ-011 SHALL have ports mem_rd and mem_wr, output, 1 bit each: memory read and write strobes.
REQ-012 SHALL have port mem_wdata, output, 8 bits: write data.
REQ-013 SHALL have port mem_rdata, input, 8 bits: read data.
REQ-014 SHALL have port mem_ready, input, 1 bit: access complete in the current cycle.
REQ-015 SHALL have ports busy and done, output, 1 bit each; and port flags, output, 4 bits: {2'b00, carry, zero}.

Function
REQ-016 SHALL store operands little-endian: byte i is at base+i, and byte 0 is least significant.
REQ-017 SHALL implement states IDLE, RD_A, RD_B, WR, DONE.
REQ-018 In IDLE, start=1 SHALL latch all inputs, clear the byte index, set carry to carry_in and zero to 1, then go to RD_A.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 RD_A SHALL drive mem_rd=1 and mem_addr=a_base+i, hold both until mem_ready=1, then capture mem_rdata and go to RD_B.
REQ-021 RD_B SHALL behave the same as RD_A with address b_base+i, then go to WR.
REQ-022 WR SHALL drive mem_wr=1, mem_addr=a_base+i and mem_wdata=result, holding them until mem_ready=1.
REQ-023 On mem_ready in WR, the block SHALL update carry to the byte carry-out and AND (result==0) into zero.
REQ-024 On mem_ready in WR, the block SHALL go to DONE if i==len, otherwise increment i and go to RD_A.
REQ-025 mem_rd and mem_wr SHALL never be high together, and both SHALL be 0 outside RD_A, RD_B and WR.
REQ-026 Per-byte arithmetic SHALL work on the low nibble and then the high nibble, with the low-nibble carry feeding the high nibble.
REQ-027 Each nibble SHALL compute t = a+b+c (add) or a-b-c (sub) as a 5-bit modulo-32 value.
REQ-028 If t>9 (unsigned), nibble carry SHALL be 1 and nibble result SHALL be t[3:0]+6 (add) or t[3:0]-6 (sub), modulo 16.
REQ-029 If t<=9, nibble carry SHALL be 0 and nibble result SHALL be t[3:0].
REQ-030 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 DONE SHALL last exactly one cycle, with done=1, then return to IDLE.
REQ-033 flags SHALL hold the final {0,0,carry,zero} from DONE until the next accepted start.
REQ-034 With mem_ready tied to 1, a start accepted at cycle T SHALL give done at cycle T+3*(len+1)+1.

Reset
REQ-035 reset_n=0 SHALL immediately force state IDLE, and force busy, done, mem_rd, mem_wr, mem_addr, mem_wdata, flags and i all to 0.
REQ-036 A reset during an operation SHALL abort it with no further memory access; bytes already written are not restored.

Verification
REQ-037 add, len=0, A=0x45, B=0x38, cin=0 -> mem[A]=0x83, flags=0000, done at T+4.
REQ-038 add, len=1, A=0x0099, B=0x0001, cin=0 -> A=0x0100, flags=0000, 6 writes/reads in order rdA,rdB,wr per byte.
REQ-039 sub, len=0, A=0x00, B=0x01, cin=0 -> mem[A]=0x99, flags=0010; add 0x50+0x50 -> 0x00, flags=0011.
REQ-040 mem_ready held low 3 cycles on every access, len=2 -> addresses and strobes stable while waiting, result identical to the zero-wait run.
REQ-041 start pulsed while busy -> ignored; reset_n low during the second RD_B of len=3 -> all outputs 0 at once, and no further mem_wr after release.
